// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline boundary register family: default
// payload widths, the default NOP instruction encoding and the occupancy type.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int          PC_W_DEF      = 32;
    localparam int          INSTR_W_DEF   = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // Number of entries held by a stage: 0..2 with skid, 0..1 without.
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/if_id_pipe_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_pipe_stage_if
// One valid/ready channel carrying a PC/instruction pair.
//   valid : producer offers pc/instr
//   ready : consumer can accept
//   pc    : program counter payload
//   instr : instruction payload
// Modports:
//   master : producer side (drives valid/pc/instr, samples ready)
//   slave  : consumer side (samples valid/pc/instr, drives ready)
// -----------------------------------------------------------------------------
interface if_id_pipe_stage_if
    import pipe_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               valid;
    logic               ready;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;

    modport master (output valid, output pc, output instr, input  ready);
    modport slave  (input  valid, input  pc, input  instr, output ready);

endinterface

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Second-entry storage for a pipeline boundary register. Only present when
// IF_ID_PIPE_SKID_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : discard the held entry
//   load_i     : capture pc_i/instr_i, entry becomes full
//   unload_i   : entry handed to the main register, becomes empty
//   pc_i/instr_i : payload to capture
//   full_o     : an entry is held
//   pc_o/instr_o : held payload
// -----------------------------------------------------------------------------
`ifdef IF_ID_PIPE_SKID_EN
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               unload_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               full_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o
);
    logic               full_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
        end else if (unload_i) begin
            full_q <= 1'b0;
        end
    end

    // Payload is qualified by full_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule
`endif

// File: rtl/if_id_pipe_stage.sv
// -----------------------------------------------------------------------------
// if_id_pipe_stage
// Fetch/decode boundary register with valid/ready handshake, optional 2-entry
// skid buffering, synchronous flush (returns to the reset state) and freeze
// (holds state and presents a bubble on both sides).
// Build option: define IF_ID_PIPE_SKID_EN for the 2-entry skid version with
// registered in_ready; otherwise a single register with in_ready
// combinational from out_ready.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : discard all entries (priority over freeze)
//   freeze      : hold all state, no transfers either side
//   in_if       : slave channel from fetch (in_valid/in_ready/in_pc/in_instr)
//   out_if      : master channel to decode (out_valid/out_ready/out_pc/out_instr)
//   occupancy   : entries currently held
// -----------------------------------------------------------------------------
module if_id_pipe_stage
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              freeze,
    if_id_pipe_stage_if.slave  in_if,
    if_id_pipe_stage_if.master out_if,
    output occ_t              occupancy
);
    // alive_q keeps in_ready low while reset is held and for the release cycle.
    logic               alive_q;
    occ_t               occ_q, occ_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    logic               main_vld, in_rdy, out_vld, in_fire, out_fire;
    logic               skid_full;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    // Entries fill main first, so main holds data whenever anything is held.
    assign main_vld = (occ_q != 2'd0);
    assign out_vld  = main_vld && !freeze;
    assign in_fire  = in_if.valid && in_rdy;
    assign out_fire = out_vld && out_if.ready;

`ifdef IF_ID_PIPE_SKID_EN
    logic skid_load, skid_unload;

    // Depends only on registered occupancy: no path from out_ready.
    assign in_rdy      = alive_q && (occ_q != 2'd2) && !freeze;
    assign skid_load   = !flush && in_fire && main_vld && !out_fire;
    assign skid_unload = !flush && out_fire && skid_full;

    pipe_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .pc_i     (in_if.pc),
        .instr_i  (in_if.instr),
        .full_o   (skid_full),
        .pc_o     (skid_pc),
        .instr_o  (skid_instr)
    );

    assign occupancy = occ_q;
`else
    assign in_rdy     = alive_q && (!main_vld || out_if.ready) && !freeze;
    assign skid_full  = 1'b0;
    assign skid_pc    = '0;
    assign skid_instr = '0;
    assign occupancy  = {1'b0, occ_q[0]};
`endif

    always_comb begin
        occ_d   = occ_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            occ_d   = '0;
            pc_d    = '0;
            instr_d = NOP_INSTR;
        end else if (!freeze) begin
            occ_d = occ_q + occ_t'(in_fire) - occ_t'(out_fire);
            if (out_fire && skid_full) begin
                // Skid refills main; in_ready was low so no new entry arrives.
                pc_d    = skid_pc;
                instr_d = skid_instr;
            end else if (in_fire && (!main_vld || out_fire)) begin
                pc_d    = in_if.pc;
                instr_d = in_if.instr;
            end
            // A drain with nothing behind it keeps the last payload visible.
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
            occ_q   <= '0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            alive_q <= 1'b1;
            occ_q   <= occ_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign in_if.ready  = in_rdy;
    assign out_if.valid = out_vld;
    assign out_if.pc    = pc_q;
    assign out_if.instr = instr_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
module tb_if_id_pipe_stage;
    import pipe_pkg::*;

    localparam int          PC_W    = 32;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] NOP     = 32'h0000_0000;
`ifdef IF_ID_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n, flush, freeze;
    occ_t occupancy;

    if_id_pipe_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) in_if ();
    if_id_pipe_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) out_if ();

    if_id_pipe_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .freeze    (freeze),
        .in_if     (in_if.slave),
        .out_if    (out_if.master),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a FIFO of held entries plus the last payload shown.
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic [31:0] last_pc, last_instr;
    bit          alive;

    function automatic bit exp_in_ready();
        if (!alive || freeze) return 1'b0;
        if (CAP == 2) return q_pc.size() < 2;
        return (q_pc.size() == 0) || (out_if.ready === 1'b1);
    endfunction

    function automatic bit exp_out_valid();
        return (q_pc.size() > 0) && !freeze;
    endfunction

    function automatic logic [31:0] exp_pc();
        return (q_pc.size() > 0) ? q_pc[0] : last_pc;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (q_instr.size() > 0) ? q_instr[0] : last_instr;
    endfunction

    task automatic model_reset();
        q_pc.delete();
        q_instr.delete();
        last_pc    = '0;
        last_instr = NOP;
        alive      = 1'b0;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit          fin, fout;
        logic [31:0] ipc, iins;
        fin  = (in_if.valid === 1'b1) && exp_in_ready();
        fout = exp_out_valid() && (out_if.ready === 1'b1);
        ipc  = in_if.pc;
        iins = in_if.instr;
        @(posedge clk);
        if (flush) begin
            q_pc.delete();
            q_instr.delete();
            last_pc    = '0;
            last_instr = NOP;
        end else begin
            if (fout) begin
                last_pc    = q_pc.pop_front();
                last_instr = q_instr.pop_front();
            end
            if (fin) begin
                q_pc.push_back(ipc);
                q_instr.push_back(iins);
            end
        end
        alive = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; freeze = 1'b0;
        in_if.valid = 1'b0; in_if.pc = '0; in_if.instr = '0; out_if.ready = 1'b0;
        model_reset();
        #2;
        n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_if.ready); end
        n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_if.valid); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        n_checks++; if (out_if.pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h want 0", out_if.pc); end
        n_checks++; if (out_if.instr !== NOP) begin n_fail++; $display("FAIL rst_out_instr: got %h want %h", out_if.instr, NOP); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_pre_edge: got %b want 0", in_if.ready); end
        tick();
        n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", in_if.ready); end
        // Fill to capacity, then reset mid-stream.
        in_if.valid = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            in_if.pc = 32'h100 + 32'(4 * i); in_if.instr = 32'hA000_0000 + 32'(i);
            tick();
        end
        in_if.valid = 1'b0; #1;
        n_checks++; if (occupancy !== occ_t'(CAP)) begin n_fail++; $display("FAIL fill_occ: got %0d want %0d", occupancy, CAP); end
        rst_n = 1'b0; model_reset(); #1;
        n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_if.valid); end
        n_checks++; if (out_if.instr !== NOP) begin n_fail++; $display("FAIL midrst_out_instr: got %h want %h", out_if.instr, NOP); end
        n_checks++; if (out_if.pc !== 32'h0) begin n_fail++; $display("FAIL midrst_out_pc: got %h want 0", out_if.pc); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL midrst_occ: got %0d want 0", occupancy); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_if.ready); end
    endtask

    task automatic test_stream();
        out_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_if.valid = 1'b1; in_if.pc = 32'(4 * i); in_if.instr = 32'h2008_0001 + 32'(i);
            tick();
            n_checks++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_if.valid); end
            n_checks++; if (out_if.pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_if.pc, 4 * i); end
            n_checks++; if (out_if.instr !== 32'h2008_0001 + 32'(i)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_if.instr, 32'h2008_0001 + i); end
            n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
        end
        in_if.valid = 1'b0;
        tick();
        n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_if.valid); end
        n_checks++; if (out_if.pc !== 32'h8) begin n_fail++; $display("FAIL drain_hold_pc: got %h want 8", out_if.pc); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL drain_occ: got %0d want 0", occupancy); end
        out_if.ready = 1'b0;
    endtask

`ifdef IF_ID_PIPE_SKID_EN
    task automatic test_skid();
        out_if.ready = 1'b0; in_if.valid = 1'b1;
        in_if.pc = 32'h0; in_if.instr = 32'hB000_0000; tick();
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_occ1: got %0d want 1", occupancy); end
        n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL skid_rdy1: got %b want 1", in_if.ready); end
        in_if.pc = 32'h4; in_if.instr = 32'hB000_0004; tick();
        in_if.pc = 32'h8; in_if.instr = 32'hB000_0008; tick();
        n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_occ2: got %0d want 2", occupancy); end
        n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL skid_rdy_full: got %b want 0", in_if.ready); end
        n_checks++; if (out_if.pc !== 32'h0) begin n_fail++; $display("FAIL skid_head_pc: got %h want 0", out_if.pc); end
        out_if.ready = 1'b1; #1;
        n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL skid_rdy_no_comb: got %b want 0", in_if.ready); end
        tick();
        n_checks++; if (out_if.pc !== 32'h4) begin n_fail++; $display("FAIL skid_refill_pc: got %h want 4", out_if.pc); end
        n_checks++; if (out_if.instr !== 32'hB000_0004) begin n_fail++; $display("FAIL skid_refill_instr: got %h want b0000004", out_if.instr); end
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_refill_occ: got %0d want 1", occupancy); end
        n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL skid_rdy_back: got %b want 1", in_if.ready); end
        tick();
        n_checks++; if (out_if.pc !== 32'h8) begin n_fail++; $display("FAIL skid_third_pc: got %h want 8", out_if.pc); end
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_third_occ: got %0d want 1", occupancy); end
        in_if.valid = 1'b0; tick();
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL skid_empty_occ: got %0d want 0", occupancy); end
        out_if.ready = 1'b0;
    endtask
`else
    task automatic test_comb_ready();
        out_if.ready = 1'b0; in_if.valid = 1'b1;
        in_if.pc = 32'h40; in_if.instr = 32'hC000_0040; tick();
        in_if.valid = 1'b0; #1;
        n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL comb_rdy_low: got %b want 0", in_if.ready); end
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL comb_occ: got %0d want 1", occupancy); end
        out_if.ready = 1'b1; #1;
        n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL comb_rdy_high: got %b want 1", in_if.ready); end
        tick();
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL comb_drain_occ: got %0d want 0", occupancy); end
        out_if.ready = 1'b0;
    endtask
`endif

    task automatic test_freeze();
        out_if.ready = 1'b0; in_if.valid = 1'b1;
        in_if.pc = 32'h10; in_if.instr = 32'hD000_0010; tick();
        in_if.pc = 32'h14; in_if.instr = 32'hD000_0014;
        freeze = 1'b1; out_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL frz_valid[%0d]: got %b want 0", i, out_if.valid); end
            n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL frz_ready[%0d]: got %b want 0", i, in_if.ready); end
            n_checks++; if (out_if.pc !== 32'h10) begin n_fail++; $display("FAIL frz_pc[%0d]: got %h want 10", i, out_if.pc); end
            n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL frz_occ[%0d]: got %0d want 1", i, occupancy); end
            tick();
        end
        freeze = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b0; #1;
        n_checks++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL frz_release_valid: got %b want 1", out_if.valid); end
        n_checks++; if (out_if.pc !== 32'h10) begin n_fail++; $display("FAIL frz_release_pc: got %h want 10", out_if.pc); end
        out_if.ready = 1'b1; tick(); out_if.ready = 1'b0;
    endtask

    task automatic test_flush();
        out_if.ready = 1'b0; in_if.valid = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            in_if.pc = 32'h200 + 32'(4 * i); in_if.instr = 32'hE000_0000 + 32'(i);
            tick();
        end
        flush = 1'b1; freeze = 1'b1; out_if.ready = 1'b1;
        in_if.pc = 32'h300; in_if.instr = 32'hE000_0300;
        tick();
        flush = 1'b0; freeze = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b0; #1;
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_if.valid); end
        n_checks++; if (out_if.pc !== 32'h0) begin n_fail++; $display("FAIL flush_pc: got %h want 0", out_if.pc); end
        n_checks++; if (out_if.instr !== NOP) begin n_fail++; $display("FAIL flush_instr: got %h want %h", out_if.instr, NOP); end
        n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_if.ready); end
        in_if.valid = 1'b1; in_if.pc = 32'h400; in_if.instr = 32'hE000_0400; tick();
        in_if.valid = 1'b0; #1;
        n_checks++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL post_flush_valid: got %b want 1", out_if.valid); end
        n_checks++; if (out_if.pc !== 32'h400) begin n_fail++; $display("FAIL post_flush_pc: got %h want 400", out_if.pc); end
        out_if.ready = 1'b1; tick(); out_if.ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_if.valid  = ($urandom_range(0, 99) < 70);
            out_if.ready = ($urandom_range(0, 99) < 60);
            freeze       = ($urandom_range(0, 99) < 10);
            flush        = ($urandom_range(0, 99) < 4);
            in_if.pc     = $urandom;
            in_if.instr  = $urandom;
            #1;
            n_checks++; if (in_if.ready !== exp_in_ready()) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_if.ready, exp_in_ready()); end
            n_checks++; if (out_if.valid !== exp_out_valid()) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_if.valid, exp_out_valid()); end
            n_checks++; if (out_if.pc !== exp_pc()) begin n_fail++; $display("FAIL rnd_out_pc[%0d]: got %h want %h", c, out_if.pc, exp_pc()); end
            n_checks++; if (out_if.instr !== exp_instr()) begin n_fail++; $display("FAIL rnd_out_instr[%0d]: got %h want %h", c, out_if.instr, exp_instr()); end
            n_checks++; if (occupancy !== occ_t'(q_pc.size())) begin n_fail++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", c, occupancy, q_pc.size()); end
            tick();
        end
        flush = 1'b0; freeze = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
`ifdef IF_ID_PIPE_SKID_EN
        test_skid();
`else
        test_comb_ready();
`endif
        test_freeze();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
